// File: rtl/cvxif_copro_dispatcher.sv
// CVXIF dispatcher: routes issued custom instructions to NumCopro coprocessors by opcode and
// merges their results round-robin into a result FIFO. Optional counters: CVXIF_DISPATCH_PERF_EN.
module cvxif_copro_dispatcher #(
  parameter int unsigned NumCopro     = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned ResFifoDepth = 4,
  parameter logic [6:0]  CoproOpcodes [NumCopro] = '{7'h2B, 7'h0B}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [IdWidth-1:0]           issue_id_i,
  input  logic [2*XLEN-1:0]            issue_rs_i,
  output logic                         issue_resp_valid_o,
  output logic                         issue_resp_accept_o,
  output logic                         issue_resp_we_o,
  output logic [NumCopro-1:0]          cp_issue_valid_o,
  input  logic [NumCopro-1:0]          cp_issue_ready_i,
  input  logic [NumCopro-1:0]          cp_issue_accept_i,
  input  logic [NumCopro-1:0]          cp_issue_we_i,
  output logic [31:0]                  cp_instr_o,
  output logic [IdWidth-1:0]           cp_id_o,
  output logic [2*XLEN-1:0]            cp_rs_o,
  input  logic [NumCopro-1:0]          cp_result_valid_i,
  output logic [NumCopro-1:0]          cp_result_ready_o,
  input  logic [NumCopro*IdWidth-1:0]  cp_result_id_i,
  input  logic [NumCopro*XLEN-1:0]     cp_result_data_i,
  input  logic [NumCopro-1:0]          cp_result_we_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [IdWidth-1:0]           result_id_o,
  output logic [XLEN-1:0]              result_data_o,
  output logic                         result_we_o,
  output logic [31:0]                  perf_issued_o,
  output logic [31:0]                  perf_rejected_o
);

  localparam int unsigned MaxOut = 1 << IdWidth;
  localparam int unsigned OutW   = IdWidth + 1;
  localparam int unsigned PtrW   = (ResFifoDepth > 1) ? $clog2(ResFifoDepth) : 1;
  localparam int unsigned CntW   = $clog2(ResFifoDepth + 1);
  localparam int unsigned SelW   = (NumCopro > 1) ? $clog2(NumCopro) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]          state;
  logic [NumCopro-1:0] target_oh;
  logic [NumCopro-1:0] dec_oh;
  logic                dec_hit;
  logic                resp_acc;
  logic                resp_we;
  logic                offer_taken;
  logic                issue_hs;
  logic [OutW-1:0]     outstanding;
  logic                out_inc;
  logic                out_dec;

  // Lowest channel index wins when several channels share an opcode
  always_comb begin
    dec_oh  = '0;
    dec_hit = 1'b0;
    for (int unsigned j = 0; j < NumCopro; j++) begin
      if (!dec_hit && issue_instr_i[6:0] == CoproOpcodes[j]) begin
        dec_oh[j] = 1'b1;
        dec_hit   = 1'b1;
      end
    end
  end

  assign issue_ready_o       = (state == ST_IDLE) && (outstanding < OutW'(MaxOut));
  assign issue_hs            = issue_valid_i && issue_ready_o;
  assign offer_taken         = (state == ST_OFFER) && |(cp_issue_ready_i & target_oh);
  assign cp_issue_valid_o    = (state == ST_OFFER) ? target_oh : '0;
  assign issue_resp_valid_o  = (state == ST_RESP);
  assign issue_resp_accept_o = issue_resp_valid_o && resp_acc;
  assign issue_resp_we_o     = issue_resp_valid_o && resp_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      target_oh  <= '0;
      resp_acc   <= 1'b0;
      resp_we    <= 1'b0;
      cp_instr_o <= '0;
      cp_id_o    <= '0;
      cp_rs_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (issue_hs) begin
          cp_instr_o <= issue_instr_i;
          cp_id_o    <= issue_id_i;
          cp_rs_o    <= issue_rs_i;
          target_oh  <= dec_oh;
          resp_acc   <= 1'b0;
          resp_we    <= 1'b0;
          state      <= dec_hit ? ST_OFFER : ST_RESP;
        end
        ST_OFFER: if (offer_taken) begin
          resp_acc <= |(cp_issue_accept_i & target_oh);
          resp_we  <= |(cp_issue_we_i & target_oh);
          state    <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_inc = issue_resp_accept_o;
  assign out_dec = result_valid_o && result_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (out_inc && !out_dec && outstanding != OutW'(MaxOut)) begin
      outstanding <= outstanding + 1'b1;
    end else if (out_dec && !out_inc && outstanding != '0) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  logic [SelW-1:0]    rr_ptr;
  logic [SelW-1:0]    gsel;
  logic               g_found;
  int unsigned        arb_idx;
  logic [IdWidth-1:0] push_id;
  logic [XLEN-1:0]    push_data;
  logic               push_we;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [CntW-1:0]    count;
  logic [IdWidth-1:0] mem_id   [ResFifoDepth];
  logic [XLEN-1:0]    mem_data [ResFifoDepth];
  logic               mem_we   [ResFifoDepth];

  assign fifo_full  = (count == CntW'(ResFifoDepth));
  assign fifo_empty = (count == '0);

  // Round-robin search starts at rr_ptr; no grant at all while the FIFO is full
  always_comb begin
    cp_result_ready_o = '0;
    gsel      = '0;
    g_found   = 1'b0;
    arb_idx   = 0;
    push_id   = '0;
    push_data = '0;
    push_we   = 1'b0;
    for (int unsigned k = 0; k < NumCopro; k++) begin
      arb_idx = (32'(rr_ptr) + k) % NumCopro;
      if (!g_found && !fifo_full && cp_result_valid_i[arb_idx]) begin
        g_found                    = 1'b1;
        cp_result_ready_o[arb_idx] = 1'b1;
        gsel                       = SelW'(arb_idx);
        push_id                    = cp_result_id_i[arb_idx*IdWidth +: IdWidth];
        push_data                  = cp_result_data_i[arb_idx*XLEN +: XLEN];
        push_we                    = cp_result_we_i[arb_idx];
      end
    end
  end

  assign push = g_found;
  assign pop  = !fifo_empty && result_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rr_ptr <= (gsel == SelW'(NumCopro - 1)) ? '0 : gsel + 1'b1;
        wr_ptr <= (wr_ptr == PtrW'(ResFifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrW'(ResFifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_id[wr_ptr]   <= push_id;
      mem_data[wr_ptr] <= push_data;
      mem_we[wr_ptr]   <= push_we;
    end
  end

  assign result_valid_o = !fifo_empty;
  assign result_id_o    = fifo_empty ? '0 : mem_id[rd_ptr];
  assign result_data_o  = fifo_empty ? '0 : mem_data[rd_ptr];
  assign result_we_o    = fifo_empty ? 1'b0 : mem_we[rd_ptr];

`ifdef CVXIF_DISPATCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_iss;
  logic [31:0] perf_rej;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_iss <= '0;
      perf_rej <= '0;
    end else if (issue_resp_valid_o) begin
      if (resp_acc) perf_iss <= sat_inc(perf_iss);
      else          perf_rej <= sat_inc(perf_rej);
    end
  end

  assign perf_issued_o   = perf_iss;
  assign perf_rejected_o = perf_rej;
`else
  assign perf_issued_o   = '0;
  assign perf_rejected_o = '0;
`endif

endmodule

// File: tb/tb_cvxif_copro_dispatcher.sv
// Bench for cvxif_copro_dispatcher: table-driven issue vectors, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a queue-based reference model.
module tb_cvxif_copro_dispatcher;
  localparam int NC = 2;
  localparam int XL = 64;
  localparam int IW = 2;
  localparam int DEPTH = 4;
  localparam int MAXOUT = 4;

  logic clk = 1'b0;
  logic rst_i;
  logic issue_valid;
  logic issue_ready;
  logic [31:0] issue_instr;
  logic [IW-1:0] issue_id;
  logic [2*XL-1:0] issue_rs;
  logic resp_valid, resp_accept, resp_we;
  logic [NC-1:0] cp_issue_valid, cp_issue_ready, cp_issue_accept, cp_issue_we;
  logic [31:0] cp_instr;
  logic [IW-1:0] cp_id;
  logic [2*XL-1:0] cp_rs;
  logic [NC-1:0] res_valid, res_ready, res_we;
  logic [NC*IW-1:0] res_id;
  logic [NC*XL-1:0] res_data;
  logic result_valid, result_ready, result_we;
  logic [IW-1:0] result_id;
  logic [XL-1:0] result_data;
  logic [31:0] perf_issued, perf_rejected;

  always #5 clk = ~clk;

  cvxif_copro_dispatcher #(.NumCopro(NC), .XLEN(XL), .IdWidth(IW), .ResFifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs_i(issue_rs),
    .issue_resp_valid_o(resp_valid), .issue_resp_accept_o(resp_accept), .issue_resp_we_o(resp_we),
    .cp_issue_valid_o(cp_issue_valid), .cp_issue_ready_i(cp_issue_ready),
    .cp_issue_accept_i(cp_issue_accept), .cp_issue_we_i(cp_issue_we),
    .cp_instr_o(cp_instr), .cp_id_o(cp_id), .cp_rs_o(cp_rs),
    .cp_result_valid_i(res_valid), .cp_result_ready_o(res_ready), .cp_result_id_i(res_id),
    .cp_result_data_i(res_data), .cp_result_we_i(res_we),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_data_o(result_data), .result_we_o(result_we),
    .perf_issued_o(perf_issued), .perf_rejected_o(perf_rejected)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [XL-1:0] data;
    logic          we;
  } res_t;

  typedef struct {
    logic [6:0]    opc;
    logic [IW-1:0] id;
    int            delay;
    logic          acc;
    logic          we;
    int            tgt;
    logic          eacc;
    logic          ewe;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;

  res_t mq[$];
  int m_rr, m_out;
  logic [31:0] m_iss, m_rej;
  logic exp_idle;
  logic [NC-1:0] exp_offer;
  logic exp_rv, exp_ra, exp_rw;
  logic [31:0] exp_instr;
  logic [IW-1:0] exp_id;
  logic [2*XL-1:0] exp_rs;
  bit rand_res = 0;
  bit force_pop = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_target(input logic [6:0] op);
    if (op == 7'h2B) return 0;
    if (op == 7'h0B) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 0;
    m_out = 0;
    m_iss = 0;
    m_rej = 0;
    exp_idle = 1'b1;
    exp_offer = '0;
    exp_rv = 1'b0;
    exp_ra = 1'b0;
    exp_rw = 1'b0;
  endtask

  task automatic randomize_results();
    for (int j = 0; j < NC; j++) begin
      res_valid[j] = 1'($urandom_range(0, 1));
      res_id[j*IW +: IW] = IW'($urandom);
      res_data[j*XL +: XL] = {$urandom, $urandom};
      res_we[j] = 1'($urandom_range(0, 1));
    end
    result_ready = force_pop ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // One clock: check outputs at the falling edge, advance the model, then move past the rising edge
  task automatic step();
    logic [NC-1:0] eg;
    int g;
    bit pop, inc;
    @(negedge clk);
    eg = '0;
    g = -1;
    if (mq.size() < DEPTH) begin
      for (int k = 0; k < NC; k++) begin
        int j;
        j = (m_rr + k) % NC;
        if (g < 0 && res_valid[j]) begin
          g = j;
          eg[j] = 1'b1;
        end
      end
    end
    chk("cp_result_ready", 128'(res_ready), 128'(eg));
    chk("result_valid", 128'(result_valid), 128'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("result_id", 128'(result_id), 128'(mq[0].id));
      chk("result_data", 128'(result_data), 128'(mq[0].data));
      chk("result_we", 128'(result_we), 128'(mq[0].we));
    end else begin
      chk("result_head_zero", 128'({result_id, result_data, result_we}), 128'(0));
    end
    chk("issue_ready", 128'(issue_ready), 128'(exp_idle && m_out < MAXOUT));
    chk("cp_issue_valid", 128'(cp_issue_valid), 128'(exp_offer));
    if (exp_offer != '0) begin
      chk("cp_instr", 128'(cp_instr), 128'(exp_instr));
      chk("cp_id", 128'(cp_id), 128'(exp_id));
      chk("cp_rs", 128'(cp_rs), 128'(exp_rs));
    end
    chk("resp_valid", 128'(resp_valid), 128'(exp_rv));
    chk("resp_accept", 128'(resp_accept), 128'(exp_rv && exp_ra));
    chk("resp_we", 128'(resp_we), 128'(exp_rv && exp_rw));
`ifdef CVXIF_DISPATCH_PERF_EN
    chk("perf_issued", 128'(perf_issued), 128'(m_iss));
    chk("perf_rejected", 128'(perf_rejected), 128'(m_rej));
`else
    chk("perf_tied_zero", 128'({perf_issued, perf_rejected}), 128'(0));
`endif
    if (rst_i) begin
      model_reset();
    end else begin
      pop = (mq.size() > 0) && result_ready;
      inc = exp_rv && exp_ra;
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{res_id[g*IW +: IW], res_data[g*XL +: XL], res_we[g]});
        m_rr = (g + 1) % NC;
      end
      if (inc && !pop && m_out < MAXOUT) m_out++;
      else if (pop && !inc && m_out > 0) m_out--;
      if (exp_rv) begin
        if (exp_ra) m_iss++;
        else m_rej++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_res) randomize_results();
  endtask

  task automatic do_issue(input logic [6:0] opc, input logic [IW-1:0] id, input int delay,
                          input logic acc, input logic we, input int tgt,
                          input logic eacc, input logic ewe);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opc;
    issue_valid = 1'b1;
    issue_instr = w;
    issue_id = id;
    issue_rs = {$urandom, $urandom, $urandom, $urandom};
    exp_instr = w;
    exp_id = id;
    exp_rs = issue_rs;
    step();
    issue_valid = 1'b0;
    issue_instr = $urandom;
    issue_id = IW'($urandom);
    issue_rs = {$urandom, $urandom, $urandom, $urandom};
    exp_idle = 1'b0;
    if (tgt >= 0) begin
      exp_offer = '0;
      exp_offer[tgt] = 1'b1;
      for (int d = 0; d <= delay; d++) begin
        cp_issue_ready = NC'($urandom) & ~exp_offer;
        cp_issue_accept = NC'($urandom);
        cp_issue_we = NC'($urandom);
        if (d == delay) begin
          cp_issue_ready[tgt] = 1'b1;
          cp_issue_accept[tgt] = acc;
          cp_issue_we[tgt] = we;
        end
        step();
      end
      cp_issue_ready = '0;
      cp_issue_accept = '0;
      cp_issue_we = '0;
      exp_offer = '0;
    end
    exp_rv = 1'b1;
    exp_ra = eacc;
    exp_rw = ewe;
    step();
    exp_rv = 1'b0;
    exp_ra = 1'b0;
    exp_rw = 1'b0;
    exp_idle = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic clear_results();
    res_valid = '0;
    res_id = '0;
    res_data = '0;
    res_we = '0;
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{7'h0B, 2'd3, 0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
    vt[1] = '{7'h33, 2'd1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vt[2] = '{7'h2B, 2'd0, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vt[3] = '{7'h0B, 2'd2, 1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vt[4] = '{7'h7F, 2'd0, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0};
    vt[5] = '{7'h2B, 2'd1, 3, 1'b1, 1'b1, 0, 1'b1, 1'b1};

    rst_i = 1'b1;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_id = '0;
    issue_rs = '0;
    cp_issue_ready = '0;
    cp_issue_accept = '0;
    cp_issue_we = '0;
    result_ready = 1'b0;
    clear_results();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("reset_cp_instr", 128'(cp_instr), 128'(0));
    chk("reset_cp_id", 128'(cp_id), 128'(0));
    chk("reset_cp_rs", 128'(cp_rs), 128'(0));
    step();

    for (int i = 0; i < 6; i++) begin
      do_issue(vt[i].opc, vt[i].id, vt[i].delay, vt[i].acc, vt[i].we, vt[i].tgt, vt[i].eacc, vt[i].ewe);
      step();
    end

    // Outstanding limit: four accepted instructions block issue until a result pops
    do_reset();
    for (int i = 0; i < MAXOUT; i++) do_issue(7'h0B, IW'(i), 0, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    chk("out_full_ready_low", 128'(issue_ready), 128'(0));
    step();
    res_valid = 2'b01;
    res_id[IW-1:0] = 2'd2;
    res_data[XL-1:0] = 64'hCAFE_0001;
    step();
    clear_results();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    step();
    chk("out_after_pop_ready", 128'(issue_ready), 128'(1));

    // Both channels streaming: grants alternate and the FIFO preserves grant order
    do_reset();
    res_valid = 2'b11;
    res_id = {2'd1, 2'd0};
    res_data = {64'hB000_0000_0000_0001, 64'hA000_0000_0000_0000};
    res_we = 2'b10;
    result_ready = 1'b1;
    repeat (8) step();

    // Fill to depth, then simultaneous pop and push at three entries
    do_reset();
    result_ready = 1'b0;
    repeat (5) step();
    chk("full_no_grant", 128'(res_ready), 128'(0));
    clear_results();
    result_ready = 1'b1;
    step();
    res_valid = 2'b01;
    res_data[XL-1:0] = 64'h1234_5678_9ABC_DEF0;
    step();
    clear_results();
    chk("count_stays_3_head_valid", 128'(result_valid), 128'(1));
    repeat (4) step();

    // Reset while an offer is pending with two results queued
    do_reset();
    result_ready = 1'b0;
    res_valid = 2'b01;
    res_data[XL-1:0] = 64'h5555;
    repeat (2) step();
    clear_results();
    issue_valid = 1'b1;
    issue_instr = 32'h0000_002B;
    issue_id = 2'd1;
    issue_rs = '1;
    exp_instr = issue_instr;
    exp_id = issue_id;
    exp_rs = issue_rs;
    step();
    issue_valid = 1'b0;
    exp_idle = 1'b0;
    exp_offer = 2'b01;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    chk("rst_mid_offer_valid", 128'(cp_issue_valid), 128'(0));
    chk("rst_mid_offer_fifo", 128'(result_valid), 128'(0));

    // Randomized traffic against the model
    rand_res = 1;
    randomize_results();
    for (int i = 0; i < 80; i++) begin
      logic [6:0] opc;
      logic acc;
      int t, guard;
      guard = 0;
      force_pop = 1;
      while (m_out >= MAXOUT && guard < 200) begin
        step();
        guard++;
      end
      force_pop = 0;
      if (guard >= 200) chk("drain_timeout", 128'(m_out), 128'(MAXOUT - 1));
      case ($urandom_range(0, 2))
        0: opc = 7'h0B;
        1: opc = 7'h2B;
        default: opc = 7'($urandom);
      endcase
      t = m_target(opc);
      acc = 1'($urandom_range(0, 1));
      begin
        logic we;
        we = acc & 1'($urandom_range(0, 1));
        do_issue(opc, IW'($urandom), $urandom_range(0, 3), acc, we, t,
                 (t >= 0) ? acc : 1'b0, (t >= 0) ? we : 1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    rand_res = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cvxif_copro_dispatcher.md
Name: cvxif_copro_dispatcher

Overview:
- Parametrised successor to the single example-coprocessor attachment on the core's CVXIF port.
- Routes each issued custom instruction to one of NumCopro coprocessors, selected by opcode.
- Tracks outstanding offloaded instructions.
- Merges coprocessor results through a round-robin arbiter into a result FIFO returned to the core.
- Instantiated in the core top-level between the cva6 CVXIF port and the coprocessor array.

Parameters:
- NumCopro, 2: number of coprocessor channels (1..8).
- XLEN, 64: operand/result width.
- IdWidth, 4: instruction id width; max outstanding = 2**IdWidth.
- ResFifoDepth, 4: result FIFO entries (>=2, any value).
- CoproOpcodes, {7'h2B,7'h0B}: NumCopro x 7-bit opcode per channel; channel j owns instr[6:0]==CoproOpcodes[j], lowest j wins on duplicates.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  core issue request valid
- issue_ready_o  out  1  dispatcher accepts request
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs_i  in  2*XLEN  {rs2,rs1} operands
- issue_resp_valid_o  out  1  one-cycle issue response pulse
- issue_resp_accept_o  out  1  instruction accepted by a coprocessor
- issue_resp_we_o  out  1  accepted instruction will write rd
- cp_issue_valid_o  out  NumCopro  per-channel offer valid
- cp_issue_ready_i  in  NumCopro  per-channel offer taken
- cp_issue_accept_i  in  NumCopro  per-channel accept (sampled with ready)
- cp_issue_we_i  in  NumCopro  per-channel writeback flag (sampled with ready)
- cp_instr_o  out  32  latched instruction (shared)
- cp_id_o  out  IdWidth  latched id (shared)
- cp_rs_o  out  2*XLEN  latched operands (shared)
- cp_result_valid_i  in  NumCopro  result valid per channel
- cp_result_ready_o  out  NumCopro  result grant per channel
- cp_result_id_i  in  NumCopro*IdWidth  result ids
- cp_result_data_i  in  NumCopro*XLEN  result data
- cp_result_we_i  in  NumCopro  result writes rd
- result_valid_o  out  1  FIFO not empty
- result_ready_i  in  1  core pops result
- result_id_o  out  IdWidth  head id
- result_data_o  out  XLEN  head data
- result_we_o  out  1  head we
- perf_issued_o  out  32  see Optional Feature
- perf_rejected_o  out  32  see Optional Feature

Behaviour:
- Reset: FSM=IDLE, outstanding=0, FIFO empty, RR pointer=0. All outputs 0 except latched payload registers, which are also cleared.
- Reset mid-operation abandons any offer and all FIFO contents.
- Issue FSM states: IDLE, OFFER, RESP.
- IDLE:
  - issue_ready_o = (outstanding < 2**IdWidth).
  - On handshake, latch instr/id/rs and decode target.
  - Opcode match → OFFER. No match → RESP with accept=0, we=0.
- OFFER:
  - cp_issue_valid_o[target]=1; all other bits 0.
  - Hold until cp_issue_ready_i[target]; capture accept/we that cycle; → RESP.
- RESP:
  - issue_resp_valid_o=1 for exactly one cycle, then → IDLE. issue_ready_o=0 in OFFER and RESP.
  - Latency for a matched instruction: issue handshake at cycle N, offer from N+1, response pulse one cycle after the coprocessor's ready.
  - Unmatched instruction: response at N+1.
- Outstanding counter:
  - +1 in the RESP cycle if accept=1.
  - −1 on a FIFO pop (result_valid_o && result_ready_i).
  - Both in the same cycle: unchanged. Never wraps.
- Result arbiter:
  - When FIFO not full, grant the first requesting channel at or after the RR pointer (cp_result_ready_o one-hot, combinational).
  - On grant, push and set pointer = granted+1 mod NumCopro. When full, cp_result_ready_o=0.
- FIFO:
  - Registered storage, read/write pointers wrap ResFifoDepth-1→0.
  - Push and pop in the same cycle permitted when not full.
  - Head outputs valid only when result_valid_o=1; otherwise 0.

Optional Feature:
- Macro: CVXIF_DISPATCH_PERF_EN.
- Defined:
  - perf_issued_o counts RESP cycles with accept=1.
  - perf_rejected_o counts RESP cycles with accept=0.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, cleared by rst_i.
- Undefined: both ports tied to 0 and no counter registers are synthesised.

Test Plan:
- Issue instr opcode 7'h0B, id 3; channel 1 ready+accept+we one cycle after offer → cp_issue_valid_o=2'b10 for one cycle; resp pulse accept=1, we=1; outstanding=1.
- Issue opcode 7'h33 → no cp_issue_valid_o; resp at N+1 with accept=0; with PERF_EN, perf_rejected_o=1.
- IdWidth=2: accept 4 instructions without popping results → issue_ready_o=0. Pop one result → issue_ready_o=1 the next cycle.
- Both channels assert result valid continuously with result_ready_i=1 → grants alternate ch0,ch1,ch0,…; FIFO order matches grant order.
- result_ready_i=0 and 4 results pushed (depth 4) → cp_result_ready_o=0. Pop and push in the same cycle at 3 entries → count stays 3.
- Assert rst_i during OFFER with 2 FIFO entries → next cycle FSM=IDLE, result_valid_o=0, outstanding=0, cp_issue_valid_o=0.
